// File: rtl/ksa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone subtractor.
package ksa_pkg;

   localparam int KSA_WIDTH_DEFAULT = 8;

   // Group propagate/generate pair carried through every prefix level.
   typedef struct packed {
      logic p;
      logic g;
   } ksa_pg_t;

   function automatic int ksa_levels(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/ksa_dot_cell.sv
// Kogge-Stone prefix operator: combines a high group with the adjacent low group.
module ksa_dot_cell (
   input  logic p_hi,
   input  logic g_hi,
   input  logic p_lo,
   input  logic g_lo,
   output logic p,
   output logic g
);

   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;

endmodule

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor (a - b - bin), one prefix level per stage,
// with a single global advance enable shared by every slot.
module ksa_sub_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int L      = ksa_levels(WIDTH);
   localparam int STAGES = L + 1;  // vld_pipe[0..L] are S0..SL, vld_pipe[STAGES] is SOUT

   logic [STAGES:0]            vld_pipe;
   ksa_pg_t [L:0][WIDTH-1:0]   pg_q;
   ksa_pg_t [L:1][WIDTH-1:0]   pg_nxt;
   ksa_pg_t [WIDTH-1:0]        pg_pre;
   logic [L:0][WIDTH-1:0]      hp_q;   // bitwise half-sum, needed unchanged by the post-process
   logic [L:0]                 cin_q;
   logic [L:0]                 sa_q;
   logic [L:0]                 sb_q;
   logic                       adv;
   logic [WIDTH:0]             c;
   logic [WIDTH-1:0]           diff_nxt;
   logic                       bout_nxt;
   logic                       ovf_nxt;

   assign out_valid = vld_pipe[STAGES];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;

   // Subtraction as a + ~b + ~bin.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pg_pre[i].p = a[i] ^ ~b[i];
         pg_pre[i].g = a[i] & ~b[i];
      end
   end

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int D = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= D) begin : g_dot
            ksa_dot_cell u_dot (
               .p_hi (pg_q[k-1][i].p),
               .g_hi (pg_q[k-1][i].g),
               .p_lo (pg_q[k-1][i-D].p),
               .g_lo (pg_q[k-1][i-D].g),
               .p    (pg_nxt[k][i].p),
               .g    (pg_nxt[k][i].g)
            );
         end else begin : g_pass
            assign pg_nxt[k][i] = pg_q[k-1][i];
         end
      end
   end

   always_comb begin
      c[0] = cin_q[L];
      for (int i = 0; i < WIDTH; i++)
         c[i+1] = pg_q[L][i].g | (pg_q[L][i].p & cin_q[L]);
      diff_nxt = hp_q[L] ^ c[WIDTH-1:0];
      bout_nxt = ~c[WIDTH];
      ovf_nxt  = (sa_q[L] ^ sb_q[L]) & (diff_nxt[WIDTH-1] ^ sa_q[L]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         diff     <= '0;
         bout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
         diff     <= diff_nxt;
         bout     <= bout_nxt;
         ovf      <= ovf_nxt;
      end
   end

   // Datapath slots carry no reset; their contents only matter alongside a set valid bit.
   always_ff @(posedge clk) begin
      if (adv) begin
         pg_q[0]  <= pg_pre;
         hp_q[0]  <= a ^ ~b;
         cin_q[0] <= ~bin;
         sa_q[0]  <= a[WIDTH-1];
         sb_q[0]  <= b[WIDTH-1];
         for (int k = 1; k <= L; k++) begin
            pg_q[k]  <= pg_nxt[k];
            hp_q[k]  <= hp_q[k-1];
            cin_q[k] <= cin_q[k-1];
            sa_q[k]  <= sa_q[k-1];
            sb_q[k]  <= sb_q[k-1];
         end
      end
   end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Bench for ksa_sub_pipe: arithmetic reference model plus a per-cycle scoreboard.
module tb_ksa_sub_pipe;
   import ksa_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int n_cons   = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } res_t;

   res_t exp_q[$];

   ksa_sub_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Plain integer arithmetic: unsigned compare for borrow, signed range for overflow.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      res_t r;
      int   s;
      s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      r.d  = ma - mb - W'(mbin);
      r.bo = int'(ma) < (int'(mb) + int'(mbin));
      r.ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1) - 1));
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Scoreboard, sampled on the falling edge.
   logic [W-1:0] hold_d;
   logic         hold_b, hold_o;
   logic         hold_v = 1'b0;
   res_t         mr;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (hold_v) begin
            check("hold_diff", 32'(diff), 32'(hold_d));
            check("hold_bout", 32'(bout), 32'(hold_b));
            check("hold_ovf",  32'(ovf),  32'(hold_o));
            check("hold_valid", 32'(out_valid), 32'd1);
         end
         hold_v = out_valid && !out_ready;
         hold_d = diff;
         hold_b = bout;
         hold_o = ovf;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'd1, 32'd0);
            end else begin
               mr = exp_q.pop_front();
               check("sb_diff", 32'(diff), 32'(mr.d));
               check("sb_bout", 32'(bout), 32'(mr.bo));
               check("sb_ovf",  32'(ovf),  32'(mr.ov));
            end
            n_cons++;
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one operation, measures latency in edges counting the accepting edge.
   task automatic send_one(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vbin, input logic [W-1:0] ed, input logic eb, input logic eo);
      int lat;
      a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'd5);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_diff"}, 32'(diff), 32'(ed));
      check({name, "_bout"}, 32'(bout), 32'(eb));
      check({name, "_ovf"},  32'(ovf),  32'(eo));
      @(posedge clk); #1;
   endtask

   logic [W-1:0] va[100], vb[100];
   logic         vbn[100];
   res_t         pin;

   initial begin
      int base, idx, stall_left, ir_low, k, fc, lc, guard;
      bit stall_done, acc;

      // Pin the reference model with hand-computed results.
      pin = model(8'h80, 8'h01, 1'b0);
      check("model_pin_80_01", {23'd0, pin.d, pin.bo}, {23'd0, 8'h7F, 1'b0});
      check("model_pin_80_01_ovf", 32'(pin.ov), 32'd1);
      pin = model(8'h05, 8'h05, 1'b1);
      check("model_pin_05_05_1", {22'd0, pin.d, pin.bo, pin.ov}, {22'd0, 8'hFF, 1'b1, 1'b0});

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_bout", 32'(bout), 32'd0);
      check("reset_ovf",  32'(ovf),  32'd0);
      rst = 1'b0;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      send_one("v50_30",   8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0);
      send_one("v00_01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      send_one("v80_01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      send_one("v05_05_1", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
      send_one("v7f_ff",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      send_one("v00_00_1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      send_one("v00_00",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

      // 20 back-to-back operations with a 3-cycle downstream stall after 4 results.
      for (int i = 0; i < 100; i++) begin
         va[i] = W'($urandom); vb[i] = W'($urandom); vbn[i] = 1'($urandom);
      end
      base = n_cons; idx = 0; stall_left = 0; stall_done = 0; ir_low = 0;
      k = 0; fc = -1; lc = -1; guard = 0;
      while ((n_cons - base) < 20 && guard < 200) begin
         in_valid = (idx < 20);
         if (idx < 20) begin a = va[idx]; b = vb[idx]; bin = vbn[idx]; end
         if (!stall_done && (n_cons - base) >= 4) begin stall_left = 3; stall_done = 1; end
         out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (!in_ready) ir_low++;
         if (out_valid && out_ready) begin
            if (fc < 0) fc = k;
            lc = k;
         end
         @(posedge clk); #1;
         if (acc) idx++;
         k++; guard++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stall_results", 32'(n_cons - base), 32'd20);
      check("stall_in_ready_low", 32'(ir_low), 32'd3);
      check("stall_span", 32'(lc - fc), 32'd22);
      check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         a = 8'h40 + W'(i); b = 8'h01; bin = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_diff", 32'(diff), 32'd0);
      check("midrst_bout", 32'(bout), 32'd0);
      check("midrst_ovf",  32'(ovf),  32'd0);
      rst = 1'b0;
      base = n_cons; ir_low = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) ir_low++;
      end
      check("midrst_no_ghosts", 32'(ir_low), 32'd0);
      check("midrst_no_cons", 32'(n_cons - base), 32'd0);

      // 100 cycles of simultaneous accept and consume.
      base = n_cons; ir_low = 0;
      for (int i = 0; i < 100; i++) begin
         a = va[i]; b = vb[i]; bin = vbn[i]; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         if (!in_ready) ir_low++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      guard = 0;
      while ((n_cons - base) < 100 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("tput_in_ready_low", 32'(ir_low), 32'd0);
      check("tput_results", 32'(n_cons - base), 32'd100);
      check("tput_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
